// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: capture FSM states and grant encoding.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_CAM  = 2'd2
    } grant_t;

endpackage

// File: rtl/dmem_arb_core.sv
// Priority arbiter between CPU and camera with a starvation counter that
// forces a camera slot after STARVE_MAX consecutive denied cycles.
module dmem_arb_core
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   cpu_req,
    input  logic   cam_wr,
    output grant_t grant
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + 1'b1;
    endfunction

    // Reset suppresses every grant so no memory write can slip out that cycle.
    always_comb begin
        grant = GNT_NONE;
        if (reset) begin
            grant = GNT_NONE;
        end else if (cam_wr && (starve_cnt == CNT_MAX)) begin
            grant = GNT_CAM;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end else if (cam_wr) begin
            grant = GNT_CAM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!cam_wr || (grant == GNT_CAM)) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU memory stage and the
// camera frame writer; holds the capture FSM, frame word index and memory muxes.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] FB_BASE     = ADDR_W'(32'h0000_1000),
    parameter int                FRAME_WORDS = 1024,
    parameter int                STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cam_start,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_data,
    output logic              cam_ready,
    output logic              frame_done,
    output logic              capturing,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WIDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(FRAME_WORDS - 1);

    cap_state_t        state;
    logic [WIDX_W-1:0] widx;
    logic              cam_wr;
    grant_t            grant;
    logic              last_word;

    assign capturing  = (state == CAPTURE);
    assign frame_done = (state == DONE);
    assign cam_wr     = capturing && cam_valid;
    assign last_word  = (widx == WIDX_LAST);

    dmem_arb_core #(
        .STARVE_MAX(STARVE_MAX)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .cpu_req(cpu_req),
        .cam_wr (cam_wr),
        .grant  (grant)
    );

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [WIDX_W-1:0] idx);
        return FB_BASE + (ADDR_W'(idx) << 2);
    endfunction

    // Memory-side muxes; the CPU path is the default so idle cycles still
    // present cpu_addr for combinational reads.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        cam_ready = 1'b0;
        case (grant)
            GNT_CPU: begin
                mem_we = cpu_we;
            end
            GNT_CAM: begin
                mem_we    = 1'b1;
                mem_addr  = fb_addr(widx);
                mem_wdata = cam_data;
                cam_ready = 1'b1;
                cpu_stall = cpu_req;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        // Pixels arriving outside a capture are drained and dropped.
        if (!capturing && cam_valid) begin
            cam_ready = 1'b1;
        end
        if (reset) begin
            mem_we    = 1'b0;
            cpu_stall = 1'b0;
            cam_ready = 1'b0;
        end
    end

    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            widx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    widx <= '0;
                    if (cam_start) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (grant == GNT_CAM) begin
                        if (last_word) begin
                            widx  <= '0;
                            state <= DONE;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    widx  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter at its default parameters.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cam_start;
    logic        cam_valid;
    logic [31:0] cam_data;
    logic        cam_ready;
    logic        frame_done;
    logic        capturing;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_assert;
    int n_fail;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cam_start (cam_start),
        .cam_valid (cam_valid),
        .cam_data  (cam_data),
        .cam_ready (cam_ready),
        .frame_done(frame_done),
        .capturing (capturing),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at +3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0040;
        cpu_wdata = 32'h1234_5678;
        cam_start = 1'b1;
        cam_valid = 1'b1;
        cam_data  = 32'hAAAA_0000;
        mem_rdata = 32'h0;

        // Reset cycle: combinational outputs forced quiet despite active inputs
        tick();
        settle();
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_cam_ready", {31'd0, cam_ready}, 32'd0);
        tick();
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cam_start = 1'b0;
        cam_valid = 1'b0;
        settle();
        chk("rst_capturing", {31'd0, capturing}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // CPU load with camera idle
        tick();
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0020;
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("ld_stall", {31'd0, cpu_stall}, 32'd0);
        chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
        chk("ld_mem_addr", mem_addr, 32'h0000_0020);

        // CPU store passes straight through
        tick();
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_0024;
        cpu_wdata = 32'hCAFE_F00D;
        settle();
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", mem_addr, 32'h0000_0024);
        chk("st_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;

        // Pixels in IDLE are drained without writing
        cam_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cam_data = 32'hBB00_0000 + i;
            settle();
            chk("idle_cam_ready", {31'd0, cam_ready}, 32'd1);
            chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
            tick();
        end

        // Start with a simultaneous pixel: that pixel is dropped
        cam_start = 1'b1;
        cam_data  = 32'hFFFF_FFFF;
        settle();
        chk("start_drop_we", {31'd0, mem_we}, 32'd0);
        chk("start_drop_ready", {31'd0, cam_ready}, 32'd1);
        tick();
        cam_start = 1'b0;

        // Full frame, with a stray cam_start mid-frame that must be ignored
        for (int i = 0; i < 1024; i++) begin
            cam_data  = i;
            cam_start = (i == 500);
            settle();
            chk("frm_capturing", {31'd0, capturing}, 32'd1);
            chk("frm_mem_we", {31'd0, mem_we}, 32'd1);
            chk("frm_mem_addr", mem_addr, 32'h0000_1000 + 4 * i);
            chk("frm_mem_wdata", mem_wdata, i);
            chk("frm_frame_done", {31'd0, frame_done}, 32'd0);
            tick();
        end
        cam_start = 1'b0;
        settle();
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("done_capturing", {31'd0, capturing}, 32'd0);
        chk("done_mem_we", {31'd0, mem_we}, 32'd0);
        chk("done_cam_ready", {31'd0, cam_ready}, 32'd1);
        tick();
        settle();
        chk("post_frame_done", {31'd0, frame_done}, 32'd0);
        chk("post_capturing", {31'd0, capturing}, 32'd0);
        chk("post_mem_we", {31'd0, mem_we}, 32'd0);

        // Contention: CPU and camera both asserted for the whole window
        cam_valid = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0300;
        cam_start = 1'b1;
        tick();
        cam_start = 1'b0;
        cam_valid = 1'b1;
        for (int j = 0; j < 15; j++) begin
            cam_data = 32'hC000_0000 + j;
            settle();
            if ((j % 5) == 4) begin
                chk("arb_cam_stall", {31'd0, cpu_stall}, 32'd1);
                chk("arb_cam_we", {31'd0, mem_we}, 32'd1);
                chk("arb_cam_addr", mem_addr, 32'h0000_1000 + 4 * (j / 5));
                chk("arb_cam_ready", {31'd0, cam_ready}, 32'd1);
            end else begin
                chk("arb_cpu_stall", {31'd0, cpu_stall}, 32'd0);
                chk("arb_cpu_we", {31'd0, mem_we}, 32'd0);
                chk("arb_cpu_addr", mem_addr, 32'h0000_0300);
                chk("arb_cpu_ready", {31'd0, cam_ready}, 32'd0);
            end
            tick();
        end

        // Abort a frame after 300 words with reset
        cpu_req   = 1'b0;
        cam_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        cam_start = 1'b1;
        tick();
        cam_start = 1'b0;
        cam_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cam_data = 32'hD000_0000 + i;
            settle();
            chk("abort_mem_addr", mem_addr, 32'h0000_1000 + 4 * i);
            tick();
        end
        reset = 1'b1;
        settle();
        chk("abort_rst_we", {31'd0, mem_we}, 32'd0);
        chk("abort_rst_ready", {31'd0, cam_ready}, 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("abort_no_done", {31'd0, frame_done}, 32'd0);
            chk("abort_idle", {31'd0, capturing}, 32'd0);
            tick();
        end
        cam_start = 1'b1;
        tick();
        cam_start = 1'b0;
        cam_data  = 32'hE000_0001;
        settle();
        chk("restart_addr", mem_addr, 32'h0000_1000);
        chk("restart_wdata", mem_wdata, 32'hE000_0001);
        chk("restart_we", {31'd0, mem_we}, 32'd1);
        tick();
        settle();
        chk("restart_addr2", mem_addr, 32'h0000_1004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
